// File: rtl/caxi4interconnect_fifo_downsize_if.sv
// Handshake bundle for the width-down FIFO: wide write side and narrow
// valid/ready read side, plus the occupancy flags.
interface caxi4interconnect_fifo_downsize_if #(
   parameter int DATA_WIDTH_IN  = 128,
   parameter int DATA_WIDTH_OUT = 32
);
   localparam int LW = $clog2(DATA_WIDTH_IN / DATA_WIDTH_OUT);

   logic                      wr_en;
   logic [DATA_WIDTH_IN-1:0]  data_in;
   logic [LW-1:0]             wr_lanes;
   logic                      rd_ready;
   logic                      rd_valid;
   logic [DATA_WIDTH_OUT-1:0] data_out;
   logic                      rd_last;
   logic                      wr_overflow;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_nearly_full;
   logic                      fifo_nearly_empty;
   logic                      fifo_one_from_full;

   // FIFO side
   modport slave (
      input  wr_en, data_in, wr_lanes, rd_ready,
      output rd_valid, data_out, rd_last, wr_overflow,
             fifo_full, fifo_empty, fifo_nearly_full,
             fifo_nearly_empty, fifo_one_from_full
   );

   // Producer / consumer side
   modport master (
      output wr_en, data_in, wr_lanes, rd_ready,
      input  rd_valid, data_out, rd_last, wr_overflow,
             fifo_full, fifo_empty, fifo_nearly_full,
             fifo_nearly_empty, fifo_one_from_full
   );
endinterface

// File: rtl/caxi4interconnect_fifo_downsize.sv
// Width-down FIFO: stores one wide entry (plus its lane count) per write and
// replays it as narrow beats, lane 0 first, with first-word fall-through.
// Flags count whole entries; a partially drained head still counts as one.
module caxi4interconnect_fifo_downsize #(
   parameter int MEM_DEPTH           = 16,
   parameter int DATA_WIDTH_IN       = 128,
   parameter int DATA_WIDTH_OUT      = 32,
   parameter int NEARLY_FULL_THRESH  = 12,
   parameter int NEARLY_EMPTY_THRESH = 2
) (
   input  logic clk,
   input  logic rst,
   caxi4interconnect_fifo_downsize_if.slave bus
);
   localparam int R               = DATA_WIDTH_IN / DATA_WIDTH_OUT;
   localparam int LW              = $clog2(R);
   localparam bit CLAMP           = ($clog2(MEM_DEPTH) < 2);
   localparam int FIFO_SIZE       = CLAMP ? 4 : MEM_DEPTH;
   localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_SIZE);
   localparam int CW              = $clog2(FIFO_SIZE + 1);
   localparam int NEARLY_FULL     = CLAMP ? 3 : NEARLY_FULL_THRESH;
   localparam int NEARLY_EMPTY    = CLAMP ? 1 : NEARLY_EMPTY_THRESH;
   localparam int EW              = DATA_WIDTH_IN + LW;

   localparam logic [CW-1:0]              C_FULL     = CW'(FIFO_SIZE);
   localparam logic [CW-1:0]              C_ONE_FULL = CW'(FIFO_SIZE - 1);
   localparam logic [CW-1:0]              C_NFULL    = CW'(NEARLY_FULL);
   localparam logic [CW-1:0]              C_NEMPTY   = CW'(NEARLY_EMPTY);
   localparam logic [FIFO_ADDR_WIDTH-1:0] C_LAST_PTR = FIFO_ADDR_WIDTH'(FIFO_SIZE - 1);

   logic [EW-1:0]              r_mem [FIFO_SIZE];
   logic [FIFO_ADDR_WIDTH-1:0] r_wrptr;
   logic [FIFO_ADDR_WIDTH-1:0] r_rdptr;
   logic [CW-1:0]              r_count;
   logic [LW-1:0]              r_lane_cnt;
   logic                       r_wr_overflow;

   logic [EW-1:0]             w_head;
   logic [LW-1:0]             w_head_lanes;
   logic [DATA_WIDTH_OUT-1:0] w_lane [2**LW];
   logic                      w_full;
   logic                      w_empty;
   logic                      w_wr_acc;
   logic                      w_beat;
   logic                      w_last;
   logic                      w_pop;

   // Pointers wrap explicitly so non-power-of-two depths also work.
   function automatic logic [FIFO_ADDR_WIDTH-1:0] ptr_inc(input logic [FIFO_ADDR_WIDTH-1:0] p);
      return (p == C_LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign w_full       = (r_count == C_FULL);
   assign w_empty      = (r_count == '0);
   assign w_head       = r_mem[r_rdptr];
   assign w_head_lanes = w_head[EW-1 -: LW];

   // Split the head entry into lanes; slots beyond R read as zero.
   for (genvar gi = 0; gi < 2**LW; gi++) begin : g_lane
      if (gi < R) begin : g_used
         assign w_lane[gi] = w_head[DATA_WIDTH_OUT*gi +: DATA_WIDTH_OUT];
      end else begin : g_unused
         assign w_lane[gi] = '0;
      end
   end

   assign w_last   = !w_empty && (r_lane_cnt == w_head_lanes);
   assign w_wr_acc = bus.wr_en && !w_full;
   assign w_beat   = !w_empty && bus.rd_ready;
   assign w_pop    = w_beat && w_last;

   assign bus.rd_valid           = !w_empty;
   assign bus.data_out           = w_lane[r_lane_cnt];
   assign bus.rd_last            = w_last;
   assign bus.wr_overflow        = r_wr_overflow;
   assign bus.fifo_full          = w_full;
   assign bus.fifo_empty         = w_empty;
   assign bus.fifo_one_from_full = (r_count == C_ONE_FULL);
   assign bus.fifo_nearly_full   = (r_count >= C_NFULL);
   assign bus.fifo_nearly_empty  = (r_count <= C_NEMPTY);

   // Entry storage: no reset, contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wrptr] <= {bus.wr_lanes, bus.data_in};
      end
   end

   // Pointer, lane, occupancy and overflow-pulse state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrptr       <= '0;
         r_rdptr       <= '0;
         r_count       <= '0;
         r_lane_cnt    <= '0;
         r_wr_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wrptr <= ptr_inc(r_wrptr);
         end
         if (w_pop) begin
            r_rdptr    <= ptr_inc(r_rdptr);
            r_lane_cnt <= '0;
         end else if (w_beat) begin
            r_lane_cnt <= r_lane_cnt + 1'b1;
         end
         case ({w_wr_acc, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A write arriving while full is dropped even if a pop frees a slot.
         r_wr_overflow <= bus.wr_en && w_full;
      end
   end
endmodule

// File: tb/tb_caxi4interconnect_fifo_downsize.sv
// Bench for the width-down FIFO: directed scenarios plus random traffic,
// checked every cycle against a queue-of-entries reference model.
module tb_caxi4interconnect_fifo_downsize;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   caxi4interconnect_fifo_downsize_if #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32)) ifc();

   caxi4interconnect_fifo_downsize #(
      .MEM_DEPTH(DEPTH), .DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32),
      .NEARLY_FULL_THRESH(12), .NEARLY_EMPTY_THRESH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   typedef struct {
      logic [127:0] d;
      int           lanes;
   } entry_t;

   entry_t q[$];
   int     m_lc  = 0;
   bit     m_ovf = 1'b0;
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare every DUT output with what the entry queue says it should be.
   task automatic check_outputs();
      int sz = q.size();
      chk("rd_valid", ifc.rd_valid, sz != 0);
      if (sz != 0) begin
         chk("data_out", ifc.data_out, q[0].d[32*m_lc +: 32]);
         chk("rd_last", ifc.rd_last, m_lc == q[0].lanes);
      end else begin
         chk("rd_last", ifc.rd_last, 1'b0);
      end
      chk("full", ifc.fifo_full, sz == DEPTH);
      chk("empty", ifc.fifo_empty, sz == 0);
      chk("one_from_full", ifc.fifo_one_from_full, sz == DEPTH - 1);
      chk("nearly_full", ifc.fifo_nearly_full, sz >= 12);
      chk("nearly_empty", ifc.fifo_nearly_empty, sz <= 2);
      chk("wr_overflow", ifc.wr_overflow, m_ovf);
   endtask

   // One clock: check, drive, advance the model, then move past the edge.
   task automatic step(input bit we, input logic [127:0] d, input logic [1:0] ln, input bit rr);
      int  sz;
      bit  was_full;
      entry_t e;
      check_outputs();
      ifc.wr_en    = we;
      ifc.data_in  = d;
      ifc.wr_lanes = ln;
      ifc.rd_ready = rr;
      sz       = q.size();
      was_full = (sz == DEPTH);
      if (sz > 0 && rr) begin
         if (m_lc == q[0].lanes) begin
            $display("POP entry data=%h lanes=%0d", q[0].d, q[0].lanes);
            void'(q.pop_front());
            m_lc = 0;
         end else begin
            m_lc++;
         end
      end
      m_ovf = 1'b0;
      if (we) begin
         if (was_full) begin
            m_ovf = 1'b1;
         end else begin
            e.d = d;
            e.lanes = int'(ln);
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && q.size() > 0; k++) begin
         step(1'b0, '0, 2'd0, 1'b1);
      end
      chk("drain_empty", ifc.fifo_empty, 1'b1);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] d;
      logic [31:0]  exp_beats [4];
      logic [31:0]  held;
      ifc.wr_en    = 1'b0;
      ifc.data_in  = '0;
      ifc.wr_lanes = '0;
      ifc.rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_empty", ifc.fifo_empty, 1'b1);
      chk("rst_nearly_empty", ifc.fifo_nearly_empty, 1'b1);
      chk("rst_valid", ifc.rd_valid, 1'b0);

      // Single full entry
      d = 128'h44444444_33333333_22222222_11111111;
      exp_beats[0] = 32'h11111111; exp_beats[1] = 32'h22222222;
      exp_beats[2] = 32'h33333333; exp_beats[3] = 32'h44444444;
      step(1'b1, d, 2'd3, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("t1_beat", ifc.data_out, exp_beats[k]);
         chk("t1_last", ifc.rd_last, k == 3);
         step(1'b0, '0, 2'd0, 1'b1);
      end
      chk("t1_empty", ifc.fifo_empty, 1'b1);

      // Partial entries
      step(1'b1, {64'h0, 32'hA1, 32'hA0}, 2'd1, 1'b0);
      step(1'b1, {96'h0, 32'hB0}, 2'd0, 1'b0);
      exp_beats[0] = 32'hA0; exp_beats[1] = 32'hA1; exp_beats[2] = 32'hB0;
      for (int k = 0; k < 3; k++) begin
         chk("t2_beat", ifc.data_out, exp_beats[k]);
         chk("t2_last", ifc.rd_last, k != 0);
         step(1'b0, '0, 2'd0, 1'b1);
      end
      chk("t2_empty", ifc.fifo_empty, 1'b1);

      // Fill with rd_ready low, overflow, drain; twice so pointers wrap
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, {rnd128() >> 8, 8'(i)}, 2'($urandom_range(0, 3)), 1'b0);
            if (i == DEPTH - 2) chk("t3_one_from_full", ifc.fifo_one_from_full, 1'b1);
         end
         chk("t3_full", ifc.fifo_full, 1'b1);
         step(1'b1, rnd128(), 2'd3, 1'b0);
         chk("t3_ovf", ifc.wr_overflow, 1'b1);
         step(1'b0, '0, 2'd0, 1'b0);
         chk("t3_ovf_clear", ifc.wr_overflow, 1'b0);
         drain();
      end

      // Backpressure during an entry
      d = rnd128();
      step(1'b1, d, 2'd3, 1'b0);
      step(1'b0, '0, 2'd0, 1'b1);
      held = ifc.data_out;
      chk("t4_lane1", held, d[63:32]);
      step(1'b0, '0, 2'd0, 1'b0);
      step(1'b0, '0, 2'd0, 1'b0);
      chk("t4_hold", ifc.data_out, d[63:32]);
      step(1'b0, '0, 2'd0, 1'b1);
      chk("t4_lane2", ifc.data_out, d[95:64]);
      drain();

      // Streaming at count=1: write on the same edge the head pops
      d = rnd128();
      step(1'b1, rnd128(), 2'd0, 1'b0);
      step(1'b1, d, 2'd2, 1'b1);
      chk("t5_valid", ifc.rd_valid, 1'b1);
      chk("t5_lane0", ifc.data_out, d[31:0]);
      chk("t5_one", ifc.fifo_nearly_empty && !ifc.fifo_empty, 1'b1);
      drain();

      // Reset mid-burst with five entries stored
      for (int i = 0; i < 5; i++) step(1'b1, rnd128(), 2'd3, 1'b0);
      step(1'b0, '0, 2'd0, 1'b1);
      step(1'b0, '0, 2'd0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("t6_empty", ifc.fifo_empty, 1'b1);
      chk("t6_valid", ifc.rd_valid, 1'b0);
      chk("t6_nearly_full", ifc.fifo_nearly_full, 1'b0);
      q.delete();
      m_lc  = 0;
      m_ovf = 1'b0;
      ifc.rd_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      d = rnd128();
      step(1'b1, d, 2'd3, 1'b1);
      chk("t6_lane0", ifc.data_out, d[31:0]);
      drain();

      // Random traffic; phases alternate between filling and draining
      for (int i = 0; i < 3000; i++) begin
         bit fill_phase = ((i / 300) % 2) == 0;
         bit we = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         bit rr = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step(we, rnd128(), 2'($urandom_range(0, 3)), rr);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/caxi4interconnect_fifo_downsize.md
Name: caxi4interconnect_fifo_downsize

Overview:
- Width-down (serialising) FIFO, the mirror of the interconnect's width-up FIFO.
- Accepts one wide entry per write and returns it as a sequence of narrow beats, least-significant lane first, under a valid/ready handshake.
- Used in the AXI4 data-width convertors where a wide slave's RDATA or a wide master's write buffer feeds a narrower port.
- Each entry carries its own lane count, so partial (narrow-burst or unaligned) entries are emitted without padding beats.

Parameters:
- MEM_DEPTH, 16: entry depth. If clog2(MEM_DEPTH) < 2, the depth is forced to 4.
- DATA_WIDTH_IN, 128: write (wide) width.
- DATA_WIDTH_OUT, 32: read (narrow) width. R = DATA_WIDTH_IN/DATA_WIDTH_OUT must be an integer and at least 2. LW = clog2(R).
- NEARLY_FULL_THRESH, 12: entry count at or above which fifo_nearly_full is asserted. Forced to 3 when the depth is clamped.
- NEARLY_EMPTY_THRESH, 2: entry count at or below which fifo_nearly_empty is asserted. Forced to 1 when the depth is clamped.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  write request for one wide entry
- data_in  in  DATA_WIDTH_IN  wide entry; lane k is bits [DATA_WIDTH_OUT*(k+1)-1 : DATA_WIDTH_OUT*k]
- wr_lanes  in  LW  number of valid lanes minus 1; lanes 0..wr_lanes are emitted
- rd_ready  in  1  consumer accepts the current beat
- rd_valid  out  1  data_out holds a valid beat
- data_out  out  DATA_WIDTH_OUT  current lane of the head entry
- rd_last  out  1  current beat is the final lane of the head entry
- wr_overflow  out  1  one-cycle pulse when a write is dropped
- fifo_full  out  1
- fifo_empty  out  1
- fifo_nearly_full  out  1
- fifo_nearly_empty  out  1
- fifo_one_from_full  out  1

Behaviour:
- Reset (async assert, released synchronously to clk):
  - wrptr, rdptr, count and lane_cnt are all 0.
  - rd_valid=0, rd_last=0, wr_overflow=0, fifo_empty=1, fifo_nearly_empty=1, all other flags 0.
  - Storage contents are don't-care.
  - Reset mid-burst discards all entries and any partially read entry. The first beat after reset is lane 0 of the next written entry.
- Storage:
  - FIFO_SIZE entries, each DATA_WIDTH_IN+LW bits (data plus lane count).
  - Write address wrptr, read address rdptr, both FIFO_ADDR_WIDTH bits, wrapping modulo FIFO_SIZE.
- Write:
  - Accepted when wr_en=1 and fifo_full=0 at the clock edge.
  - An accepted write stores {wr_lanes, data_in} at wrptr and increments wrptr.
  - If wr_en=1 while fifo_full=1, the write is dropped and wr_overflow pulses for one cycle. It is dropped even if a pop happens in the same cycle.
- Read:
  - rd_valid = !fifo_empty.
  - data_out = lane lane_cnt of the entry at rdptr. This is a combinational mux of the registered state.
  - rd_last = rd_valid && (lane_cnt == stored lanes).
  - Latency: an entry written at edge N presents lane 0 on rd_valid after edge N (first-word fall-through, 1 cycle).
- Beat transfer when rd_valid && rd_ready:
  - If rd_last: the entry is popped, rdptr increments, lane_cnt returns to 0.
  - Otherwise lane_cnt increments.
  - With rd_ready low, data_out, rd_last and lane_cnt hold.
- count (0..FIFO_SIZE) is the number of stored entries:
  - +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
  - A simultaneous write and pop at count=1 makes the new entry visible the following cycle with no bubble.
- Flags are combinational from the count register:
  - fifo_full: count == FIFO_SIZE
  - fifo_empty: count == 0
  - fifo_one_from_full: count == FIFO_SIZE-1
  - fifo_nearly_full: count >= NEARLY_FULL
  - fifo_nearly_empty: count <= NEARLY_EMPTY
- Flags count whole entries. A partially drained head entry still counts as 1 until its last beat.
- Lane counts: a wr_lanes value of R-1 gives a full entry. A value of 0 gives a single beat, with rd_last on that beat.

Test Plan:
- Single full entry:
  - Stimulus: write data_in=0x44444444_33333333_22222222_11111111, wr_lanes=3, rd_ready=1.
  - Response: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting the cycle after the write. rd_last only on 0x44444444. fifo_empty=1 afterwards.
- Partial entries:
  - Stimulus: write entry A with wr_lanes=1 (lanes 0xA0, 0xA1), then entry B with wr_lanes=0 (lane 0xB0).
  - Response: 3 beats 0xA0, 0xA1(last), 0xB0(last). No beats from unused lanes.
- Fill with rd_ready=0:
  - Stimulus: 16 writes, then a 17th write.
  - Response: fifo_one_from_full=1 at count 15. fifo_full=1 at count 16. The 17th write is dropped with wr_overflow=1 for 1 cycle. Readback yields entries 0..15 in order, and rdptr wraps correctly on a second fill.
- Backpressure:
  - Stimulus: toggle rd_ready 1,0,0,1 during an entry.
  - Response: data_out and rd_last stable while stalled. lane_cnt advances only on handshake cycles. No beat lost or duplicated.
- Streaming at count=1:
  - Stimulus: write a new entry on the same edge the last beat of the head entry pops.
  - Response: count stays 1, rd_valid stays 1 with no bubble, lane 0 of the new entry appears on the next cycle.
- Reset mid-burst:
  - Stimulus: assert rst after lane 1 of a 4-lane entry, with 5 entries stored.
  - Response: flags go to empty immediately, asynchronously, and rd_valid=0. After release, a single write emits its lane 0 first.
